// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared datapath constants for the register file.
package reg_file_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT = 32;
  localparam int REG_ZERO = 0;
  localparam int XLEN = 32;
endpackage

// File: rtl/reg_file_mux.sv
// reg_file_mux: 2:1 data mux used for read-port write-through forwarding.
module reg_file_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_in0,
  input  logic [WIDTH-1:0] i_in1,
  input  logic             i_sel,
  output logic [WIDTH-1:0] o_out
);
  always_comb o_out = i_sel ? i_in1 : i_in0;
endmodule

// File: rtl/reg_file.sv
// reg_file: 2R1W integer register file, register 0 hardwired to zero.
// Optional write-through forwarding when REGFILE_BYPASS_EN is defined.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = REG_COUNT,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [WIDTH-1:0]  rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata2
);
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] ZERO_A = REG_ZERO[ADDR_W-1:0];
  logic [WIDTH-1:0] r_regs [0:DEPTH-1];
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_arr1;
  logic [WIDTH-1:0] w_arr2;
  always_comb begin
    w_wr_ok = we && waddr != ZERO_A && {1'b0, waddr} < DEPTH_L;
    w_arr1 = (raddr1 != ZERO_A && {1'b0, raddr1} < DEPTH_L) ? r_regs[raddr1] : '0;
    w_arr2 = (raddr2 != ZERO_A && {1'b0, raddr2} < DEPTH_L) ? r_regs[raddr2] : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[waddr] <= wdata;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic w_hit1;
  logic w_hit2;
  always_comb begin
    w_hit1 = rst_n && w_wr_ok && waddr == raddr1;
    w_hit2 = rst_n && w_wr_ok && waddr == raddr2;
  end
  reg_file_mux #(.WIDTH(WIDTH)) u_mux1 (.i_in0(w_arr1), .i_in1(wdata), .i_sel(w_hit1), .o_out(rdata1));
  reg_file_mux #(.WIDTH(WIDTH)) u_mux2 (.i_in0(w_arr2), .i_in1(wdata), .i_sel(w_hit2), .o_out(rdata2));
`else
  assign rdata1 = w_arr1;
  assign rdata2 = w_arr2;
`endif
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: scoreboard bench for reg_file; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    string       name;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        chk_req = 1'b0;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  reg_file dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2)
  );
  always #5 clk = ~clk;
  always @(posedge chk_req) begin
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL monitor: strobe with empty scoreboard");
    end else begin
      exp_t e;
      e = sb.pop_front();
      checks += 2;
      if (rdata1 !== e.e1) begin
        errors++;
        $display("FAIL %s rdata1: got %h expected %h", e.name, rdata1, e.e1);
      end
      if (rdata2 !== e.e2) begin
        errors++;
        $display("FAIL %s rdata2: got %h expected %h", e.name, rdata2, e.e2);
      end
    end
  end
  task automatic expect_rd(input string n, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = n;
    e.e1 = e1;
    e.e2 = e2;
    sb.push_back(e);
    #1 chk_req = 1'b1;
    #1 chk_req = 1'b0;
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1;
    waddr = a;
    wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask
  initial begin
    raddr1 = 5'd5;
    raddr2 = 5'd31;
    we = 1'b1;
    waddr = 5'd5;
    wdata = 32'hFFFF_FFFF;
    #2 expect_rd("reset_held", 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    expect_rd("reset_write_blocked", 32'h0, 32'h0);
    rst_n = 1'b1;
    we = 1'b0;
    for (int a = 1; a < 32; a++) begin
      raddr1 = 5'(a);
      raddr2 = 5'(32 - a);
      expect_rd("post_reset_zero", 32'h0, 32'h0);
    end
    wr(5'd5, 32'hDEAD_BEEF);
    raddr1 = 5'd5;
    raddr2 = 5'd6;
    expect_rd("write_read", 32'hDEAD_BEEF, 32'h0);
    wr(5'd0, 32'hFFFF_FFFF);
    raddr1 = 5'd0;
    raddr2 = 5'd5;
    expect_rd("reg0_write_ignored", 32'h0, 32'hDEAD_BEEF);
    wr(5'd7, 32'h1234_5678);
    @(negedge clk);
    we = 1'b1;
    waddr = 5'd7;
    wdata = 32'hAAAA_AAAA;
    raddr1 = 5'd7;
    raddr2 = 5'd7;
    expect_rd("hazard_before_edge", BYP ? 32'hAAAA_AAAA : 32'h1234_5678,
              BYP ? 32'hAAAA_AAAA : 32'h1234_5678);
    @(negedge clk);
    we = 1'b0;
    expect_rd("hazard_after_edge", 32'hAAAA_AAAA, 32'hAAAA_AAAA);
    we = 1'b1;
    waddr = 5'd0;
    wdata = 32'hFFFF_FFFF;
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    expect_rd("reg0_no_bypass", 32'h0, 32'h0);
    @(negedge clk);
    we = 1'b0;
    wr(5'd3, 32'h5555_5555);
    raddr1 = 5'd3;
    raddr2 = 5'd3;
    expect_rd("dual_read", 32'h5555_5555, 32'h5555_5555);
    waddr = 5'd3;
    wdata = 32'h0;
    @(negedge clk);
    expect_rd("we_low_hold", 32'h5555_5555, 32'h5555_5555);
    wr(5'd31, 32'h8000_0001);
    wr(5'd1, 32'h0000_0001);
    raddr1 = 5'd31;
    raddr2 = 5'd1;
    expect_rd("edge_regs", 32'h8000_0001, 32'h0000_0001);
    wr(5'd9, 32'h0BAD_F00D);
    raddr1 = 5'd9;
    raddr2 = 5'd5;
    expect_rd("reg9_written", 32'h0BAD_F00D, 32'hDEAD_BEEF);
    @(negedge clk);
    #1 rst_n = 1'b0;
    expect_rd("mid_reset_now", 32'h0, 32'h0);
    we = 1'b1;
    waddr = 5'd9;
    wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1'b1;
    we = 1'b0;
    expect_rd("mid_reset_released", 32'h0, 32'h0);
    wr(5'd9, 32'hCAFE_0009);
    expect_rd("write_after_reset", 32'hCAFE_0009, 32'h0);
    #5;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
